// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - state encodings and parameter defaults for the UART word assembler
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PUSH    = 2'd1,
        ST_STALL   = 2'd2
    } rx_state_e;

    localparam int DEF_BYTES_PER_WORD = 3;
    localparam int DEF_BYTE_W         = 8;
    localparam int DEF_MSB_FIRST      = 1;
    localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/uart_rx_word_assembler_if.sv
// rtl/uart_rx_word_assembler_if.sv - byte-in / word-out handshake bundle of the word assembler
interface uart_rx_word_assembler_if
    import uart_rx_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int BYTE_W         = DEF_BYTE_W
);
    logic                               rx_ready;
    logic [BYTE_W-1:0]                  rx_data;
    logic                               word_ack;
    logic [BYTES_PER_WORD*BYTE_W-1:0]   word_data;
    logic                               word_valid;

    modport master (output rx_ready, rx_data, word_ack, input word_data, word_valid);
    modport slave  (input rx_ready, rx_data, word_ack, output word_data, word_valid);
endinterface

// File: rtl/rx_timeout_cnt.sv
// rtl/rx_timeout_cnt.sv - inter-byte idle counter with one-cycle expiry pulse (built under UART_RX_TIMEOUT_EN)
`ifdef UART_RX_TIMEOUT_EN
module rx_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = uart_rx_pkg::DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic restart,
    output logic expire,
    output logic timeout_pulse
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] idle_cnt;

    // Expiry fires on the edge that completes the TIMEOUT_CYCLES-th idle cycle.
    assign expire = active && !restart && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= expire;
            if (!active || restart || expire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CW'(1);
            end
        end
    end
endmodule
`endif

// File: rtl/uart_rx_word_assembler.sv
// rtl/uart_rx_word_assembler.sv - packs received bytes into words; UART_RX_TIMEOUT_EN adds partial-word timeout
module uart_rx_word_assembler
    import uart_rx_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int BYTE_W         = DEF_BYTE_W,
    parameter int MSB_FIRST      = DEF_MSB_FIRST,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                 clock,
    input  logic                                 reset,
    uart_rx_word_assembler_if.slave              bus,
    input  logic                                 clear_flags,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]  byte_count,
    output logic [1:0]                           state_id,
    output logic                                 overflow,
    output logic                                 timeout_pulse
);
    localparam int WORD_W = BYTES_PER_WORD * BYTE_W;
    localparam int BCW    = $clog2(BYTES_PER_WORD + 1);
    localparam int LSBW   = $clog2(WORD_W);
    localparam int LANE0  = (MSB_FIRST != 0) ? WORD_W - BYTE_W : 0;

    if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_rx_word_assembler: parameter out of legal range");
    end

    rx_state_e          state, state_n;
    logic [BCW-1:0]     byte_count_n;
    logic [WORD_W-1:0]  asm_q, asm_n, word_q, word_n;
    logic [LSBW-1:0]    lane_sel;
    logic               valid_q, valid_n, overflow_n, drop, slot_free, expire;

    function automatic int lane_lsb(input int idx);
        return (MSB_FIRST != 0) ? (BYTES_PER_WORD - 1 - idx) * BYTE_W : idx * BYTE_W;
    endfunction

    assign slot_free = !valid_q || bus.word_ack;

    always_comb begin
        state_n      = state;
        byte_count_n = byte_count;
        asm_n        = asm_q;
        word_n       = word_q;
        valid_n      = valid_q;
        drop         = 1'b0;
        lane_sel     = LSBW'(lane_lsb(int'(byte_count)));
        case (state)
            ST_COLLECT: begin
                if (bus.word_ack) valid_n = 1'b0;
                if (bus.rx_ready) begin
                    asm_n[lane_sel +: BYTE_W] = bus.rx_data;
                    byte_count_n = byte_count + BCW'(1);
                    if (byte_count == BCW'(BYTES_PER_WORD - 1)) state_n = ST_PUSH;
                end else if (expire) begin
                    byte_count_n = '0;
                end
            end
            ST_PUSH, ST_STALL: begin
                if (slot_free) begin
                    word_n       = asm_q;
                    valid_n      = 1'b1;
                    byte_count_n = '0;
                    state_n      = ST_COLLECT;
                    // Only the PUSH cycle can start the next word; a stalled byte is lost.
                    if (bus.rx_ready && state == ST_PUSH) begin
                        asm_n[LANE0 +: BYTE_W] = bus.rx_data;
                        byte_count_n = BCW'(1);
                    end else begin
                        drop = bus.rx_ready;
                    end
                end else begin
                    state_n = ST_STALL;
                    drop    = bus.rx_ready;
                end
            end
            default: begin
                state_n      = ST_COLLECT;
                byte_count_n = '0;
            end
        endcase
        overflow_n = drop || (overflow && !clear_flags);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_COLLECT;
            byte_count <= '0;
            asm_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            byte_count <= byte_count_n;
            asm_q      <= asm_n;
            word_q     <= word_n;
            valid_q    <= valid_n;
            overflow   <= overflow_n;
        end
    end

    assign bus.word_data  = word_q;
    assign bus.word_valid = valid_q;
    assign state_id       = state;

`ifdef UART_RX_TIMEOUT_EN
    rx_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock         (clock),
        .reset         (reset),
        .active        (state == ST_COLLECT && byte_count != '0),
        .restart       (bus.rx_ready),
        .expire        (expire),
        .timeout_pulse (timeout_pulse)
    );
`else
    assign expire        = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

endmodule
